// File: rtl/btc_dec_obuf.sv
// Ping-pong output buffer behind the BTC decoder engine.
// The engine fills one bank while the other streams out over valid/ready.
// Each bank carries a descriptor: length, tag, error count and decode-fail.
//
//   bank state | meaning
//   B_FREE     | empty, may be written by the engine
//   B_FILL     | engine has written at least one word of the block
//   B_FULL     | block complete, waiting for the reader
//   B_READ     | reader owns the bank until its last word is accepted
//
// Reads are issued from a separate issue pointer so the next bank can start
// while the tail of the current one is still in the output pipe. The bank is
// freed only when its last word leaves the output FIFO.
module btc_dec_obuf #(
  parameter int pADDR_W  = 8,
  parameter int pDEC_NUM = 8,
  parameter int pTAG_W   = 8,
  parameter int pERR_W   = 16
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                iwrite,
  input  logic                iwfull,
  input  logic [pADDR_W-1:0]  iwaddr,
  input  logic [pDEC_NUM-1:0] iwdat,
  input  logic [pTAG_W-1:0]   iwtag,
  input  logic [pERR_W-1:0]   iwerr,
  input  logic                iwdecfail,
  output logic                owbuf_empty,
  input  logic                iready,
  output logic                oval,
  output logic                osop,
  output logic                oeop,
  output logic [pDEC_NUM-1:0] odat,
  output logic [pTAG_W-1:0]   otag,
  output logic [pERR_W-1:0]   oerr,
  output logic                odecfail,
  output logic                ooverflow
);

  localparam int DEPTH = 2**pADDR_W;

  typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL, B_READ} bank_st_t;

  bank_st_t            st_q   [2];
  bank_st_t            st_d   [2];
  logic [pADDR_W:0]    len_q  [2];
  logic [pADDR_W:0]    len_d  [2];
  logic [pTAG_W-1:0]   tag_q  [2];
  logic [pTAG_W-1:0]   tag_d  [2];
  logic [pERR_W-1:0]   err_q  [2];
  logic [pERR_W-1:0]   err_d  [2];
  logic                fail_q [2];
  logic                fail_d [2];

  logic wptr_q, wptr_d;
  logic rptr_q, rptr_d;
  logic ovf_q, ovf_d;
  logic wbe_q, wbe_d;

  // issue side
  logic               act_q, act_d;
  logic               ib_q, ib_d;
  logic [pADDR_W-1:0] ra_q, ra_d;

  // RAM read stage
  logic                rv_q, rv_d;
  logic                rsop_q, rsop_d;
  logic                reop_q, reop_d;
  logic [pDEC_NUM-1:0] rdat_q;

  // 2-entry output FIFO
  logic [pDEC_NUM-1:0] fdat_q [2];
  logic [pDEC_NUM-1:0] fdat_d [2];
  logic                fsop_q [2];
  logic                fsop_d [2];
  logic                feop_q [2];
  logic                feop_d [2];
  logic                fwp_q, fwp_d;
  logic                frp_q, frp_d;
  logic [1:0]          fcnt_q, fcnt_d;

  logic [pDEC_NUM-1:0] mem [0:1][0:DEPTH-1];

  logic               wbank_open;
  logic               wr_en;
  logic               ovf_hit;
  logic               pop;
  logic               push;
  logic               take;
  logic               space;
  logic               issue;
  logic               last;
  logic [pADDR_W-1:0] cur_addr;
  logic [2:0]         occ;

  // Handshake and issue qualifiers shared by the RAM and the state update.
  always_comb begin
    wbank_open = (st_q[wptr_q] == B_FREE) || (st_q[wptr_q] == B_FILL);
    wr_en      = ireset && iclkena && iwrite && wbank_open;
    ovf_hit    = iclkena && iwrite && !wbank_open;
    pop        = iclkena && (fcnt_q != 2'd0) && iready;
    push       = iclkena && rv_q;
    take       = iclkena && !act_q && (st_q[ib_q] == B_FULL);
    cur_addr   = act_q ? ra_q : '0;
    occ        = {1'b0, fcnt_q} + {2'b00, rv_q};
    space      = (occ < 3'd2) || (pop && (occ == 3'd2));
    issue      = (act_q || take) && space;
    last       = (({1'b0, cur_addr} + {{pADDR_W{1'b0}}, 1'b1}) == len_q[ib_q]);
  end

  // Next-state for bank FSMs, descriptors, issue side and output FIFO.
  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    tag_d  = tag_q;
    err_d  = err_q;
    fail_d = fail_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    act_d  = act_q;
    ib_d   = ib_q;
    ra_d   = ra_q;
    rv_d   = rv_q;
    rsop_d = rsop_q;
    reop_d = reop_q;
    fdat_d = fdat_q;
    fsop_d = fsop_q;
    feop_d = feop_q;
    fwp_d  = fwp_q;
    frp_d  = frp_q;
    fcnt_d = fcnt_q;

    if (wr_en) begin
      if (iwfull) begin
        st_d[wptr_q]   = B_FULL;
        len_d[wptr_q]  = {1'b0, iwaddr} + {{pADDR_W{1'b0}}, 1'b1};
        tag_d[wptr_q]  = iwtag;
        err_d[wptr_q]  = iwerr;
        fail_d[wptr_q] = iwdecfail;
        wptr_d         = ~wptr_q;
      end else begin
        st_d[wptr_q] = B_FILL;
      end
    end
    if (ovf_hit) ovf_d = 1'b1;

    if (take) st_d[ib_q] = B_READ;

    if (iclkena) begin
      rv_d = issue;
      if (issue) begin
        rsop_d = (cur_addr == '0);
        reop_d = last;
        if (last) begin
          act_d = 1'b0;
          ib_d  = ~ib_q;
        end else begin
          act_d = 1'b1;
          ra_d  = cur_addr + {{(pADDR_W-1){1'b0}}, 1'b1};
        end
      end else if (take) begin
        act_d = 1'b1;
        ra_d  = '0;
      end
    end

    if (push) begin
      fdat_d[fwp_q] = rdat_q;
      fsop_d[fwp_q] = rsop_q;
      feop_d[fwp_q] = reop_q;
      fwp_d         = ~fwp_q;
    end
    if (pop) begin
      frp_d = ~frp_q;
      if (feop_q[frp_q]) begin
        st_d[rptr_q] = B_FREE;
        rptr_d       = ~rptr_q;
      end
    end
    fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};

    wbe_d = (st_d[wptr_d] == B_FREE) || (st_d[wptr_d] == B_FILL);
  end

  // State registers with synchronous active-low reset overriding clock enable.
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]   <= B_FREE;
        len_q[b]  <= '0;
        tag_q[b]  <= '0;
        err_q[b]  <= '0;
        fail_q[b] <= 1'b0;
        fdat_q[b] <= '0;
        fsop_q[b] <= 1'b0;
        feop_q[b] <= 1'b0;
      end
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      ovf_q  <= 1'b0;
      wbe_q  <= 1'b1;
      act_q  <= 1'b0;
      ib_q   <= 1'b0;
      ra_q   <= '0;
      rv_q   <= 1'b0;
      rsop_q <= 1'b0;
      reop_q <= 1'b0;
      fwp_q  <= 1'b0;
      frp_q  <= 1'b0;
      fcnt_q <= 2'd0;
    end else if (iclkena) begin
      st_q   <= st_d;
      len_q  <= len_d;
      tag_q  <= tag_d;
      err_q  <= err_d;
      fail_q <= fail_d;
      fdat_q <= fdat_d;
      fsop_q <= fsop_d;
      feop_q <= feop_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      wbe_q  <= wbe_d;
      act_q  <= act_d;
      ib_q   <= ib_d;
      ra_q   <= ra_d;
      rv_q   <= rv_d;
      rsop_q <= rsop_d;
      reop_q <= reop_d;
      fwp_q  <= fwp_d;
      frp_q  <= frp_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Banked word RAM with one-cycle registered read.
  always_ff @(posedge iclk) begin
    if (wr_en) mem[wptr_q][iwaddr] <= iwdat;
    if (iclkena && issue) rdat_q <= mem[ib_q][cur_addr];
  end

  assign owbuf_empty = wbe_q;
  assign oval        = (fcnt_q != 2'd0);
  assign osop        = fsop_q[frp_q];
  assign oeop        = feop_q[frp_q];
  assign odat        = fdat_q[frp_q];
  assign otag        = tag_q[rptr_q];
  assign oerr        = err_q[rptr_q];
  assign odecfail    = fail_q[rptr_q];
  assign ooverflow   = ovf_q;

endmodule

// File: doc/btc_dec_obuf.md
Name: btc_dec_obuf

Overview:
- Double-banked (ping-pong) output buffer downstream of the BTC decoder engine.
- Captures hard-decision words written by the engine's last iteration, one bank per codeword.
- Streams a completed codeword out in ascending address order over a valid/ready interface, with per-block tag, error count and decode-fail status.
- Returns a buffer-free indication to the engine's write-side input.

Parameters:
pADDR_W   8   word address width; bank depth is 2**pADDR_W words
pDEC_NUM  8   bits per word (decoded bits per engine write)
pTAG_W    8   block tag width
pERR_W    16  bit-error counter width

Ports:
iclk        in   1         clock
ireset      in   1         synchronous, active-low reset
iclkena     in   1         clock enable; when low, all state holds
iwrite      in   1         write strobe from engine
iwfull      in   1         last word of block, qualified with iwrite
iwaddr      in   pADDR_W   word address
iwdat       in   pDEC_NUM  decoded bits
iwtag       in   pTAG_W    block tag, sampled on iwfull beat
iwerr       in   pERR_W    block error count, sampled on iwfull beat
iwdecfail   in   1         decode fail, sampled on iwfull beat
owbuf_empty out  1         current write bank is free; drives engine iwbuf_empty
iready      in   1         sink ready
oval        out  1         output word valid
osop        out  1         first word of block
oeop        out  1         last word of block
odat        out  pDEC_NUM  output word
otag        out  pTAG_W    block tag, stable for whole block
oerr        out  pERR_W    block error count, stable for whole block
odecfail    out  1         block decode fail, stable for whole block
ooverflow   out  1         sticky: write attempted into a non-free bank

Behaviour:
- Reset (ireset=0 at clock edge, regardless of iclkena):
  - both banks FREE; write and read pointers = bank 0.
  - oval, osop, oeop, ooverflow = 0; owbuf_empty = 1.
  - odat, otag, oerr, odecfail = 0.
  - An in-flight block is discarded.
- Per-bank state: FREE -> FILLING (first iwrite) -> FULL (iwrite & iwfull) -> READING (reader takes bank) -> FREE (oeop word accepted).
  - FREE -> FULL directly is legal for a 1-word block.
- Write side:
  - iwrite stores iwdat at iwaddr of the write bank.
  - On iwrite & iwfull: bank length = iwaddr+1; tag, err and decfail latched into the bank descriptor; bank -> FULL; write pointer toggles.
  - owbuf_empty = (write bank state is FREE or FILLING), registered, updated the cycle after each transition.
- Overflow: iwrite while the write bank is FULL or READING -> write ignored, descriptor untouched, ooverflow set to 1 until reset.
- Read side:
  - When idle and the read-pointer bank is FULL: bank -> READING; descriptor copied to otag/oerr/odecfail; RAM reads issued for addresses 0..len-1.
  - RAM read latency is 1 cycle.
  - A 2-entry skid register absorbs backpressure, so reads may run ahead by 2 words.
- Handshake:
  - A word transfers when oval & iready.
  - While oval & !iready, odat/osop/oeop hold stable.
  - oval never drops without a transfer.
- Latency and throughput:
  - With reader idle and iready=1, first oval is high exactly 3 cycles after the iwfull beat.
  - Sustained rate is 1 word/cycle with iready held high.
- Framing: osop on the address-0 word, oeop on the address len-1 word. Both are high for a 1-word block.
- On oeop transfer: bank -> FREE, read pointer toggles.
  - If the other bank is already FULL, its osop word follows in the next cycle with no bubble.
- Simultaneous events: iwfull on one bank in the same cycle as an oeop transfer from the other bank -> both transitions take effect. owbuf_empty is 1 the next cycle.
- Address wrap: iwaddr = 2**pADDR_W-1 with iwfull gives len = 2**pADDR_W. The length register is pADDR_W+1 bits wide; no truncation.
- iclkena=0: no state change, no transfer counted, outputs hold.

Test Plan:
- Reset: drive ireset=0 for 2 cycles mid-block -> oval=0, owbuf_empty=1, ooverflow=0; a following 4-word block streams intact.
- Single block: write 4 words 0xA1,0xB2,0xC3,0xD4 at addresses 0..3, iwfull on address 3, tag 0x5A, err 0x0007, iready=1 -> oval rises 3 cycles after iwfull; words appear in order; osop on 0xA1, oeop on 0xD4; otag=0x5A, oerr=7.
- Backpressure: same block with iready toggling 1,0,0,1,... -> no word lost or duplicated; odat holds during stalls; exactly 4 transfers.
- Ping-pong: two back-to-back 16-word blocks with tags 1 and 2, iready=1 -> 32 contiguous transfers; tag changes at the second osop; no idle cycle between oeop and osop.
- Overflow: fill both banks with iready=0, then write again -> owbuf_empty=0, ooverflow=1; after release, both original blocks are output unchanged.
- Edge cases: 1-word block -> osop=oeop=1 on the same beat. Full 256-word block at pADDR_W=8 -> 256 transfers with oeop on the last.
